// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared CPU definitions for the fetch stage.
// Holds the word width, the halt opcode and the fetch FSM encoding.
package fetch_unit_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    localparam logic [3:0] HLT_OPCODE = 4'hF;

    typedef enum logic [2:0] {
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD,
        ST_DROP,
        ST_HALT
    } state_t;

    function automatic logic is_halt(input logic [3:0] opcode);
        return opcode == HLT_OPCODE;
    endfunction

endpackage

// File: rtl/CLA_16bit.sv
// CLA_16bit: 16-bit two-level carry-lookahead adder/subtractor (i_sub=1 gives a-b).
// No carry-out is produced, so the generate term of the top bit is not needed.
module CLA_16bit
    import fetch_unit_pkg::*;
(
    input  word_t i_a,
    input  word_t i_b,
    input  logic  i_sub,
    output word_t o_sum
);

    word_t       w_bx;
    word_t       w_p;
    word_t       w_c;
    logic [14:0] w_g;
    logic [2:0]  w_gg;
    logic [2:0]  w_gp;
    logic [3:0]  w_gc;

    assign w_bx = i_b ^ {WORD_W{i_sub}};
    assign w_p  = i_a ^ w_bx;
    assign w_g  = i_a[14:0] & w_bx[14:0];

    genvar j;
    generate
        for (j = 0; j < 3; j++) begin : g_grp
            assign w_gg[j] = w_g[4*j+3]
                           | (w_p[4*j+3] & w_g[4*j+2])
                           | (&w_p[4*j+2 +: 2] & w_g[4*j+1])
                           | (&w_p[4*j+1 +: 3] & w_g[4*j]);
            assign w_gp[j] = &w_p[4*j +: 4];
        end
        for (j = 0; j < 4; j++) begin : g_carry
            assign w_c[4*j]   = w_gc[j];
            assign w_c[4*j+1] = w_g[4*j] | (w_p[4*j] & w_gc[j]);
            assign w_c[4*j+2] = w_g[4*j+1]
                              | (w_p[4*j+1] & w_g[4*j])
                              | (&w_p[4*j +: 2] & w_gc[j]);
            assign w_c[4*j+3] = w_g[4*j+2]
                              | (w_p[4*j+2] & w_g[4*j+1])
                              | (&w_p[4*j+1 +: 2] & w_g[4*j])
                              | (&w_p[4*j +: 3] & w_gc[j]);
        end
    endgenerate

    // second-level lookahead across the 4-bit groups
    assign w_gc[0] = i_sub;
    assign w_gc[1] = w_gg[0] | (w_gp[0] & i_sub);
    assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (&w_gp[1:0] & i_sub);
    assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (&w_gp[2:1] & w_gg[0])
                   | (&w_gp[2:0] & i_sub);

    assign o_sum = w_p ^ w_c;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with one outstanding memory request,
// a one-entry hold buffer for stalls, redirect flushing and HLT detection.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter word_t RESET_PC = 16'h0000
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  stall,
    input  logic  redirect,
    input  word_t redirect_pc,
    output logic  imem_req,
    output word_t imem_addr,
    input  logic  imem_valid,
    input  word_t imem_rdata,
    output logic  if_id_valid,
    output word_t if_id_instr,
    output word_t if_id_pc_plus2,
    output logic  halted
);

    state_t r_state;
    state_t w_state_nxt;
    word_t  r_pc;
    word_t  w_pc_nxt;
    word_t  w_pc_plus2;
    logic   r_if_valid;
    word_t  r_if_instr;
    word_t  r_if_pc2;
    word_t  r_hold_instr;
    word_t  r_hold_pc2;
    logic   r_halted;
    logic   w_req;
    logic   w_load;
    logic   w_capture;
    word_t  w_ld_instr;
    word_t  w_ld_pc2;

    CLA_16bit u_pc_add (
        .i_a   (r_pc),
        .i_b   (16'h0002),
        .i_sub (1'b0),
        .o_sum (w_pc_plus2)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_req       = 1'b0;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        w_ld_instr  = r_hold_instr;
        w_ld_pc2    = r_hold_pc2;
        case (r_state)
            ST_ISSUE: begin
                if (redirect) begin
                    w_pc_nxt = redirect_pc;
                end else if (!stall) begin
                    w_req       = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    w_pc_nxt    = redirect_pc;
                    w_state_nxt = imem_valid ? ST_ISSUE : ST_DROP;
                end else if (imem_valid) begin
                    w_capture   = stall;
                    w_load      = !stall;
                    w_ld_instr  = imem_rdata;
                    w_ld_pc2    = w_pc_plus2;
                    w_state_nxt = stall ? ST_HOLD : ST_ISSUE;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    w_pc_nxt    = redirect_pc;
                    w_state_nxt = ST_ISSUE;
                end else if (!stall) begin
                    w_load = 1'b1;
                end
            end
            ST_DROP: begin
                w_pc_nxt    = redirect ? redirect_pc : r_pc;
                w_state_nxt = imem_valid ? ST_ISSUE : ST_DROP;
            end
            ST_HALT: begin
                if (redirect) begin
                    w_pc_nxt    = redirect_pc;
                    w_state_nxt = ST_ISSUE;
                end
            end
            default: w_state_nxt = ST_ISSUE;
        endcase
        // a halt instruction freezes pc at its own address
        if (w_load) begin
            w_state_nxt = is_halt(w_ld_instr[15:12]) ? ST_HALT : ST_ISSUE;
            w_pc_nxt    = is_halt(w_ld_instr[15:12]) ? r_pc : w_pc_plus2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_ISSUE;
            r_pc         <= RESET_PC;
            r_halted     <= 1'b0;
            r_hold_instr <= '0;
            r_hold_pc2   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_halted <= w_state_nxt == ST_HALT;
            if (w_capture) begin
                r_hold_instr <= imem_rdata;
                r_hold_pc2   <= w_pc_plus2;
            end
        end
    end

    // redirect flushes even under stall; stall alone freezes IF/ID
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_valid <= 1'b0;
            r_if_instr <= '0;
            r_if_pc2   <= '0;
        end else if (redirect) begin
            r_if_valid <= 1'b0;
        end else if (!stall) begin
            r_if_valid <= w_load;
            if (w_load) begin
                r_if_instr <= w_ld_instr;
                r_if_pc2   <= w_ld_pc2;
            end
        end
    end

    assign imem_req       = w_req & rst_n;
    assign imem_addr      = r_pc;
    assign if_id_valid    = r_if_valid;
    assign if_id_instr    = r_if_instr;
    assign if_id_pc_plus2 = r_if_pc2;
    assign halted         = r_halted;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: stall  input  1  hazard hold; IF/ID must keep its contents.
REQ-005 SHALL have port: redirect  input  1  taken branch/jump from the branch-resolution stage.
REQ-006 SHALL have port: redirect_pc  input  16  target PC, valid when redirect=1.
REQ-007 SHALL have port: imem_req  output  1  one-cycle request pulse to instruction memory.
REQ-008 SHALL have port: imem_addr  output  16  fetch address; equals pc when imem_req=1.
REQ-009 SHALL have port: imem_valid  input  1  one-cycle response strobe, at least 1 cycle after imem_req.
REQ-010 SHALL have port: imem_rdata  input  16  instruction word, valid with imem_valid.
REQ-011 SHALL have port: if_id_valid  output  1  IF/ID holds a live instruction.
REQ-012 SHALL have port: if_id_instr  output  16  latched instruction.
REQ-013 SHALL have port: if_id_pc_plus2  output  16  fetch PC + 2 (feeds branch target adder).
REQ-014 SHALL have port: halted  output  1  HLT fetched; fetching stopped.

Function
REQ-015 SHALL keep exactly one memory request outstanding at most.
REQ-016 SHALL implement states ISSUE, WAIT, HOLD, DROP, HALT.
REQ-017 ISSUE: if redirect, pc<=redirect_pc, stay ISSUE, no request; else if ~stall, imem_req=1, addr=pc, ->WAIT; else stay.
REQ-018 WAIT, imem_valid & ~redirect & ~stall: load IF/ID (valid=1, instr=rdata, pc_plus2=pc+2), pc<=pc+2, ->ISSUE.
REQ-019 WAIT, imem_valid & ~redirect & stall: capture rdata and pc+2 in one-entry hold buffer, ->HOLD.
REQ-020 WAIT, redirect & imem_valid: discard rdata, pc<=redirect_pc, ->ISSUE; redirect & ~imem_valid: pc<=redirect_pc, ->DROP.
REQ-021 HOLD: redirect -> discard buffer, pc<=redirect_pc, ->ISSUE; ~stall -> load IF/ID from buffer, pc<=pc+2, ->ISSUE.
REQ-022 DROP: on imem_valid discard data, ->ISSUE; redirect in DROP updates pc again and stays DROP.
REQ-023 SHALL treat rdata[15:12]==HLT_OPCODE (4'hF), when loaded into IF/ID, as halt: pc not incremented, ->HALT, halted=1.
REQ-024 HALT: no requests; redirect -> pc<=redirect_pc, halted<=0, ->ISSUE.
REQ-025 SHALL clear if_id_valid on the cycle after any redirect (flush), regardless of stall; redirect has priority over stall.
REQ-026 With stall=1 and no redirect, SHALL hold IF/ID outputs unchanged.
REQ-027 When not loading and not stalled, SHALL clear if_id_valid (bubble).
REQ-028 PC arithmetic SHALL be 16-bit modulo; 16'hFFFE+2 wraps to 16'h0000.
REQ-029 Minimum latency: ISSUE -> IF/ID valid = 2 cycles with 1-cycle memory; throughput 1 instruction per 2 cycles.

Reset
REQ-030 On rst_n=0 asynchronously: pc=RESET_PC, state=ISSUE, imem_req=0, if_id_valid=0, if_id_instr=0, if_id_pc_plus2=0, halted=0, hold buffer cleared.
REQ-031 Reset mid-request SHALL abandon it; a late imem_valid arriving in ISSUE after reset SHALL be ignored.

Structure
REQ-032 HLT_OPCODE, state encoding, and the 16-bit word width SHALL live in the shared CPU package.
REQ-033 PC+2 SHALL use the existing CLA_16bit sub-module (Sub=0); no other sub-module.

Verification
REQ-034 Reset, 1-cycle memory, no stall: addrs 0x0000,0x0002,0x0004; if_id_pc_plus2 = 0x0002,0x0004,0x0006.
REQ-035 stall=1 arriving in WAIT with rdata=0x1234: HOLD entered, IF/ID unchanged; stall drop -> if_id_instr=0x1234 next cycle.
REQ-036 redirect to 0x0100 while WAIT (memory 3-cycle latency): stale rdata discarded, next imem_addr=0x0100, if_id_valid=0 meanwhile.
REQ-037 rdata=0xF000 fetched at pc 0x0010: halted=1, pc stays 0x0010, no further imem_req; redirect to 0x0020 resumes.
REQ-038 pc=0xFFFE fetch: next imem_addr=0x0000, if_id_pc_plus2=0x0000.
REQ-039 rst_n low while WAIT: outputs at reset values immediately; subsequent late imem_valid produces no IF/ID load.
